store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL take parameter DEPTH, default 4, meaning number of buffered write entries (power of two, 2..16).
REQ-002 SHALL provide `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide `cpu_we`, input, 1 bit: processor store request (the processor MemWrite).
REQ-005 SHALL provide `cpu_re`, input, 1 bit: processor load request.
REQ-006 SHALL provide `cpu_adr`, input, 32 bits: processor byte address; word index is [31:2].
REQ-007 SHALL provide `cpu_wd`, input, 32 bits: processor store data.
REQ-008 SHALL provide `cpu_rd`, output, 32 bits: load data returned to the processor.
REQ-009 SHALL provide `cpu_stall`, output, 1 bit: store not accepted this cycle; the processor holds its request.
REQ-010 SHALL provide `mem_we`, output, 1 bit: memory write strobe.
REQ-011 SHALL provide `mem_adr`, output, 32 bits: memory address.
REQ-012 SHALL provide `mem_wd`, output, 32 bits: memory write data.
REQ-013 SHALL provide `mem_rd`, input, 32 bits: memory combinational read data.
REQ-014 SHALL provide `empty`, output, 1 bit: no entries pending (fence/drain indication).
REQ-015 SHALL provide `full`, output, 1 bit: occupancy equals DEPTH.
REQ-016 SHALL provide `count`, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-017 SHALL hold entries {word address [31:2], data [31:0]} in a circular FIFO with head (oldest) and tail pointers that wrap modulo DEPTH.
REQ-018 SHALL give the memory port to the load when `cpu_re`=1: `mem_adr`=`cpu_adr`, `mem_we`=0, no drain that cycle.
REQ-019 SHALL drain when `cpu_re`=0 and the buffer is not empty: `mem_we`=1, `mem_adr`={head.adr,2'b00}, `mem_wd`=head.data; head advances at the clock edge.
REQ-020 SHALL drive `mem_we`=0, `mem_adr`=`cpu_adr` and `mem_wd`=0 when neither a load nor a drain occurs.
REQ-021 SHALL forward `cpu_rd` from the youngest valid entry whose address equals `cpu_adr`[31:2]; with no match, `cpu_rd`=`mem_rd`. The path is combinational, zero latency.
REQ-022 SHALL enqueue at the clock edge when `cpu_we`=1 and (not full, or a drain occurs in the same cycle).
REQ-023 SHALL make an enqueued entry visible for forwarding and draining from the next cycle, never in its own enqueue cycle.
REQ-024 SHALL assert `cpu_stall`=`cpu_we` & `full` & ~drain_now, combinationally.
REQ-025 SHALL accept a stall-free store on a full buffer when a drain occurs in the same cycle: occupancy stays at DEPTH and the pointers advance together.
REQ-026 SHALL treat `cpu_we`=`cpu_re`=1 in the same cycle as a load plus an enqueue attempt; since no drain occurs, it stalls if full.
REQ-027 SHALL keep duplicate addresses as separate entries, drained in order so the last store wins in memory.
REQ-028 SHALL change occupancy by +1 on enqueue only, -1 on drain only, and 0 when both or neither occur; it never exceeds DEPTH or underflows.
REQ-029 SHALL derive `empty`/`full` from registered occupancy only, never from same-cycle requests.

Reset
REQ-030 SHALL, while `reset`=0, immediately clear head, tail and count to 0 and all entry valid bits to 0, giving `empty`=1, `full`=0 and `count`=0.
REQ-031 SHALL, while `reset`=0, combinationally drive `mem_we`=0 and `cpu_stall`=0.
REQ-032 SHALL discard pending entries on reset mid-operation (no drain); the first drain after release uses only post-reset stores.

Structure
REQ-033 SHALL take from a shared package `sb_pkg`: the DEPTH default constant, the `sb_entry_t` struct {adr[29:0], data[31:0]}, and the pointer-width localparam.
REQ-034 SHALL implement forwarding priority selection in one sub-module `sb_fwd_match` (inputs: entries, valid bits, tail, lookup address; outputs: hit, data); FIFO control stays in `store_buffer`.

Verification
REQ-035 SHALL cover: store 0x10←0xAAAA5555 with `cpu_re`=0 on the following cycle -> next cycle `mem_we`=1, `mem_adr`=0x10, `mem_wd`=0xAAAA5555, then `empty`=1.
REQ-036 SHALL cover: store 0x20←1, then load 0x20 immediately -> `cpu_rd`=1 from forwarding, `mem_we`=0, `count`=1.
REQ-037 SHALL cover: stores 0x30←5 then 0x30←9, then load 0x30 -> `cpu_rd`=9; the drains write 5 then 9.
REQ-038 SHALL cover: DEPTH=4 with `cpu_re` held 1 and 5 stores -> fifth store has `cpu_stall`=1 and `full`=1; dropping `cpu_re` accepts the store in the drain cycle with `count` staying 4.
REQ-039 SHALL cover: wrap-around with 10 store/drain pairs -> memory order matches store order and pointers wrap cleanly.
REQ-040 SHALL cover: `reset`=0 asserted with `count`=3 -> `count`=0 and `mem_we`=0 immediately, and no stale entries are drained after release.

Source files
------------

// File: rtl/sb_pkg.sv
// sb_pkg: shared types and sizing for the store buffer and its forwarding matcher.
package sb_pkg;
    localparam int SB_DEPTH = 4;
    localparam int SB_PTR_W = $clog2(SB_DEPTH);

    typedef struct packed {
        logic [29:0] adr;
        logic [31:0] data;
    } sb_entry_t;

    // A one-entry buffer would still need a 1-bit pointer.
    function automatic int sb_ptr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: picks the youngest valid buffered store whose word address matches a load.
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PW    = sb_ptr_w(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] ent,
    input  logic [DEPTH-1:0]      valid,
    input  logic [PW-1:0]         tail,
    input  logic [29:0]           adr,
    output logic                  hit,
    output logic [31:0]           data
);
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match found is the youngest store.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = tail - PW'(i);
            if (valid[idx] && ent[idx].adr == adr) begin
                hit  = 1'b1;
                data = ent[idx].data;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular write buffer between processor and memory with load forwarding;
// drains to memory on every cycle the processor is not loading.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_we,
    input  logic                  cpu_re,
    input  logic [31:0]           cpu_adr,
    input  logic [31:0]           cpu_wd,
    output logic [31:0]           cpu_rd,
    output logic                  cpu_stall,
    output logic                  mem_we,
    output logic [31:0]           mem_adr,
    output logic [31:0]           mem_wd,
    input  logic [31:0]           mem_rd,
    output logic                  empty,
    output logic                  full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = sb_ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    sb_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  drain, enq, hit;
    logic [31:0]           fwd_data;

    assign empty = count_q == '0;
    assign full  = count_q == CW'(DEPTH);
    assign count = count_q;

    sb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd (
        .ent   (ent_q),
        .valid (valid_q),
        .tail  (tail_q),
        .adr   (cpu_adr[31:2]),
        .hit   (hit),
        .data  (fwd_data)
    );

    // A drain frees the head slot in the same edge, so a full buffer can still accept.
    always_comb begin
        drain     = reset & ~cpu_re & ~empty;
        enq       = reset & cpu_we & (~full | drain);
        cpu_stall = reset & cpu_we & full & ~drain;
        mem_we    = drain;
        mem_adr   = drain ? {ent_q[head_q].adr, 2'b00} : cpu_adr;
        mem_wd    = drain ? ent_q[head_q].data : '0;
        cpu_rd    = hit ? fwd_data : mem_rd;
        head_d    = drain ? head_q + PW'(1) : head_q;
        tail_d    = enq ? tail_q + PW'(1) : tail_q;
        count_d   = (enq && !drain) ? count_q + CW'(1) :
                    (drain && !enq) ? count_q - CW'(1) : count_q;
        valid_d   = valid_q;
        ent_d     = ent_q;
        if (drain) valid_d[head_q] = 1'b0;
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            ent_d[tail_q]   = '{adr: cpu_adr[31:2], data: cpu_wd};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q   <= '0;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stores/loads against a queue-based model, scoreboard-checked.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, reset = 1'b0, cpu_we = 1'b0, cpu_re = 1'b0;
    logic [31:0] cpu_adr = '0, cpu_wd = '0, cpu_rd, mem_adr, mem_wd, mem_rd;
    logic        cpu_stall, mem_we, empty, full;
    logic [2:0]  count;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_adr(cpu_adr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .empty(empty), .full(full), .count(count)
    );

    // Backing memory seen by the DUT, written only by its drains.
    logic [31:0] bmem [64] = '{default: 32'h0};
    assign mem_rd = bmem[mem_adr[7:2]];
    always @(posedge clk) if (mem_we) bmem[mem_adr[7:2]] <= mem_wd;

    typedef struct { logic [31:0] adr; logic [31:0] data; } ent_t;
    typedef struct { logic drain, stall, full, empty; int count; } st_t;

    logic [31:0] mm [64] = '{default: 32'h0};
    ent_t        mq [$];
    ent_t        wq [$];
    logic [31:0] rq [$];
    st_t         sq [$];
    int          checks = 0, passes = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic miss(input string name);
        checks++;
        $display("FAIL %s: DUT output with no expected entry", name);
    endtask

    function automatic logic [31:0] lookup(input logic [31:0] adr);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].adr[31:2] == adr[31:2]) return mq[i].data;
        return mm[adr[7:2]];
    endfunction

    // One processor cycle: drive inputs, record what the buffer must do, advance the model.
    task automatic cyc(input logic we, input logic re, input logic [31:0] adr,
                       input logic [31:0] wd, output logic stalled);
        st_t  s;
        logic drn;
        @(posedge clk); #1;
        cpu_we = we; cpu_re = re; cpu_adr = adr; cpu_wd = wd;
        drn     = !re && mq.size() > 0;
        stalled = we && mq.size() == DEPTH && !drn;
        s = '{drain: drn, stall: stalled, full: mq.size() == DEPTH,
              empty: mq.size() == 0, count: mq.size()};
        sq.push_back(s);
        if (re) rq.push_back(lookup(adr));
        if (drn) begin
            wq.push_back(mq[0]);
            mm[mq[0].adr[7:2]] = mq[0].data;
            void'(mq.pop_front());
        end
        if (we && !stalled) mq.push_back('{adr: {adr[31:2], 2'b00}, data: wd});
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        chk("pre_reset_count", 32'(count), 32'(mq.size()));
        reset = 1'b0; cpu_we = 1'b1; cpu_re = 1'b0; cpu_adr = 32'h50;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        mq.delete();
        cpu_we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    st_t         ms;
    ent_t        mw;
    logic [31:0] mr;
    always @(negedge clk) if (reset) begin
        if (sq.size() > 0) begin
            ms = sq.pop_front();
            chk("mem_we", 32'(mem_we), 32'(ms.drain));
            chk("cpu_stall", 32'(cpu_stall), 32'(ms.stall));
            chk("count", 32'(count), 32'(ms.count));
            chk("full", 32'(full), 32'(ms.full));
            chk("empty", 32'(empty), 32'(ms.empty));
        end
        if (mem_we) begin
            if (wq.size() > 0) begin
                mw = wq.pop_front();
                chk("mem_adr", mem_adr, mw.adr);
                chk("mem_wd", mem_wd, mw.data);
            end else miss("drain");
        end
        if (cpu_re) begin
            if (rq.size() > 0) begin
                mr = rq.pop_front();
                chk("cpu_rd", cpu_rd, mr);
            end else miss("load");
        end
    end

    initial begin
        logic        st, we, re;
        logic [31:0] adr, wd;
        st = 1'b0; we = 1'b0; adr = '0; wd = '0;
        #2;
        chk("init_count", 32'(count), 32'd0);
        chk("init_empty", 32'(empty), 32'd1);
        chk("init_full", 32'(full), 32'd0);
        chk("init_mem_we", 32'(mem_we), 32'd0);
        chk("init_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        // single store then drain
        cyc(1, 0, 32'h10, 32'hAAAA5555, st);
        cyc(0, 0, 32'h0, 32'h0, st);
        cyc(0, 0, 32'h0, 32'h0, st);
        // forward a store to an immediate load
        cyc(1, 0, 32'h20, 32'h1, st);
        cyc(0, 1, 32'h20, 32'h0, st);
        cyc(0, 0, 32'h0, 32'h0, st);
        // duplicate address, last store wins
        cyc(1, 0, 32'h30, 32'h5, st);
        cyc(1, 0, 32'h30, 32'h9, st);
        cyc(0, 1, 32'h30, 32'h0, st);
        cyc(0, 0, 32'h0, 32'h0, st);
        cyc(0, 1, 32'h30, 32'h0, st);
        // fill under continuous loads, stall, then accept in a drain cycle
        for (int i = 0; i < 5; i++) cyc(1, 1, 32'h40 + 32'(i * 4), 32'(i), st);
        cyc(1, 0, 32'h50, 32'h4, st);
        cyc(0, 1, 32'h50, 32'h0, st);
        while (mq.size() > 0) cyc(0, 0, 32'h0, 32'h0, st);
        // wrap-around
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 32'h60 + 32'((i % 3) * 4), 32'h100 + 32'(i), st);
            cyc(0, 0, 32'h0, 32'h0, st);
        end
        // reset with three pending entries
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'h70 + 32'(i * 4), 32'hDEAD0000 + 32'(i), st);
        do_reset();
        cyc(1, 0, 32'h74, 32'h77, st);
        cyc(0, 1, 32'h70, 32'h0, st);
        cyc(0, 0, 32'h0, 32'h0, st);
        cyc(0, 0, 32'h0, 32'h0, st);
        // random traffic; a stalled store is held
        st = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!st) begin
                we  = 1'($urandom % 2);
                adr = 32'($urandom_range(0, 15)) << 2;
                wd  = $urandom;
            end
            re = ($urandom % 3) == 0;
            cyc(we, re, adr, wd, st);
        end
        while (mq.size() > 0) cyc(0, 0, 32'h0, 32'h0, st);
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_re = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("final_empty", 32'(empty), 32'd1);
        chk("pending_writes", 32'(wq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
